// File: rtl/result_converter.sv
// result_converter: final stage of the sine/cosine pipeline.
// Undoes the quarter-turn angle reduction on the CORDIC cos/sin pair.
// Converts each channel to an IEEE754 single using a shared serial
// normaliser, cos first and then sin. The exponent is 128-n, where n is
// the number of left shifts needed to set the magnitude MSB.
module result_converter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] cos_in,
  input  logic [WIDTH-1:0] sin_in,
  input  logic [2:0]       flips_in,
  output logic             ready,
  output logic             valid_out,
  output logic [31:0]      cos_out,
  output logic [31:0]      sin_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROTATE,
    S_LOAD,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched inputs
  logic [WIDTH-1:0] cos_raw_q, cos_raw_d;
  logic [WIDTH-1:0] sin_raw_q, sin_raw_d;
  logic [2:0]       flips_q, flips_d;

  // Rotated values carry one extra bit so that negating -2^(WIDTH-1)
  // yields +2^(WIDTH-1) instead of wrapping back to a negative number.
  logic signed [WIDTH:0] cos_x_q, cos_x_d;
  logic signed [WIDTH:0] sin_x_q, sin_x_d;

  // Normaliser working registers; chan_q selects cos (0) or sin (1).
  logic             chan_q, chan_d;
  logic             sign_q, sign_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [5:0]       n_q, n_d;

  // Packed per-channel results and the output registers
  logic [31:0] cos_res_q, cos_res_d;
  logic [31:0] sin_res_q, sin_res_d;
  logic [31:0] cos_out_q, cos_out_d;
  logic [31:0] sin_out_q, sin_out_d;
  logic        valid_q, valid_d;

  // Datapath helpers
  logic [1:0]            quad;
  logic signed [WIDTH:0] c_ext, s_ext, ld_x;
  logic [WIDTH-1:0]      ld_mag;
  logic [7:0]            pk_exp;
  logic [31:0]           pk_word;

  // quad is (-flips) mod 4. The rotate/load/pack helpers are derived below.
  assign quad    = 2'(3'd0 - flips_q);
  assign c_ext   = {cos_raw_q[WIDTH-1], cos_raw_q};
  assign s_ext   = {sin_raw_q[WIDTH-1], sin_raw_q};
  assign ld_x    = chan_q ? sin_x_q : cos_x_q;
  assign ld_mag  = WIDTH'(ld_x[WIDTH] ? -ld_x : ld_x);
  assign pk_exp  = 8'd128 - 8'(n_q);
  assign pk_word = (mag_q == '0) ? 32'h0000_0000
                                 : {sign_q, pk_exp, mag_q[WIDTH-2 -: 23]};

  assign ready     = (state_q == S_IDLE);
  assign valid_out = valid_q;
  assign cos_out   = cos_out_q;
  assign sin_out   = sin_out_q;

  // Next-state and datapath control; every register holds unless its state updates it.
  always_comb begin
    state_d   = state_q;
    cos_raw_d = cos_raw_q;
    sin_raw_d = sin_raw_q;
    flips_d   = flips_q;
    cos_x_d   = cos_x_q;
    sin_x_d   = sin_x_q;
    chan_d    = chan_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    n_d       = n_q;
    cos_res_d = cos_res_q;
    sin_res_d = sin_res_q;
    cos_out_d = cos_out_q;
    sin_out_d = sin_out_q;
    valid_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          cos_raw_d = cos_in;
          sin_raw_d = sin_in;
          flips_d   = flips_in;
          chan_d    = 1'b0;
          state_d   = S_ROTATE;
        end
      end
      S_ROTATE: begin
        case (quad)
          2'd0:    begin cos_x_d = c_ext;  sin_x_d = s_ext;  end
          2'd1:    begin cos_x_d = -s_ext; sin_x_d = c_ext;  end
          2'd2:    begin cos_x_d = -c_ext; sin_x_d = -s_ext; end
          default: begin cos_x_d = s_ext;  sin_x_d = -c_ext; end
        endcase
        state_d = S_LOAD;
      end
      S_LOAD: begin
        sign_d = ld_x[WIDTH];
        mag_d  = ld_mag;
        n_d    = '0;
        // An already-normalised or zero magnitude needs no shifting.
        if (ld_mag == '0 || ld_mag[WIDTH-1]) begin
          state_d = S_PACK;
        end else begin
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        mag_d = mag_q << 1;
        n_d   = n_q + 6'd1;
        if (mag_q[WIDTH-2]) begin
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        if (!chan_q) begin
          cos_res_d = pk_word;
          chan_d    = 1'b1;
          state_d   = S_LOAD;
        end else begin
          sin_res_d = pk_word;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        cos_out_d = cos_res_q;
        sin_out_d = sin_res_q;
        valid_d   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; asynchronous reset aborts any conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cos_raw_q <= '0;
      sin_raw_q <= '0;
      flips_q   <= '0;
      cos_x_q   <= '0;
      sin_x_q   <= '0;
      chan_q    <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      n_q       <= '0;
      cos_res_q <= '0;
      sin_res_q <= '0;
      cos_out_q <= '0;
      sin_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cos_raw_q <= cos_raw_d;
      sin_raw_q <= sin_raw_d;
      flips_q   <= flips_d;
      cos_x_q   <= cos_x_d;
      sin_x_q   <= sin_x_d;
      chan_q    <= chan_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      n_q       <= n_d;
      cos_res_q <= cos_res_d;
      sin_res_q <= sin_res_d;
      cos_out_q <= cos_out_d;
      sin_out_q <= sin_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule
